mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: WAIT_STATES, default 2, extra wait cycles inserted before every array access (range 0-15).
REQ-002 Parameter: DEPTH, default 512, number of 32-bit words in the backing array.
REQ-003 Port: iClk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: nRst  input  1  asynchronous, active-low reset.
REQ-005 Port: iAddr  input  32  word address from the processor memory-address register.
REQ-006 Port: iData  input  32  write data from the processor memory-data register.
REQ-007 Port: iRead  input  1  read request, level-sensitive.
REQ-008 Port: iWrite  input  1  write request, level-sensitive.
REQ-009 Port: oData  output  32  read data returned to the processor (its iMemData).
REQ-010 Port: oRdy  output  1  completion handshake returned to the processor (its iRdy).
REQ-011 Port: oErr  output  1  completion with error; valid only while oRdy=1.

Function
REQ-012 FSM states SHALL be IDLE, WAIT, ACCESS, DONE.
REQ-013 In IDLE, iRead^iWrite=1 SHALL be accepted: iAddr, iData and the op SHALL be latched at that edge, and the FSM SHALL move to WAIT with counter=WAIT_STATES-1 (WAIT_STATES>0) or directly to ACCESS (WAIT_STATES=0).
REQ-014 WAIT SHALL decrement the counter each cycle and move to ACCESS on the edge where counter=0.
REQ-015 ACCESS SHALL issue exactly one array operation using the latched request, then move to DONE.
REQ-016 Reads SHALL register array data into oData on the ACCESS->DONE edge.
REQ-017 Writes SHALL commit on the ACCESS->DONE edge; oData SHALL hold its previous value.
REQ-018 Latency: oRdy SHALL first be high WAIT_STATES+2 cycles after the accepting edge.
REQ-019 In DONE, oRdy=1, and oData and oErr SHALL stay stable until iRead=iWrite=0 is sampled; the FSM then SHALL return to IDLE and drop oRdy on that edge.
REQ-020 A request held high through DONE SHALL NOT cause a second access.
REQ-021 A new request SHALL be accepted at the earliest on the edge after the return to IDLE.
REQ-022 Request inputs SHALL be ignored outside IDLE and DONE.
REQ-023 Address range: iAddr>=DEPTH SHALL complete with oErr=1, with the same latency and handshake.
   - Read: oData=0.
   - Write: dropped; array unchanged.
REQ-024 iRead=iWrite=1 in IDLE SHALL be accepted as an error request with the same effects as REQ-023 (no array access).
REQ-025 Array word index SHALL be iAddr[log2(DEPTH)-1:0], checked against the full 32-bit iAddr.

Reset
REQ-026 While nRst=0, regardless of clock:
   - FSM=IDLE, counter=0.
   - oRdy=0, oErr=0, oData=0.
   - latched request registers cleared.
REQ-027 Array contents SHALL NOT be reset.
REQ-028 Reset in WAIT or ACCESS before the commit edge SHALL abort the operation with no array write.
REQ-029 A write whose commit edge preceded reset SHALL remain in the array.

Structure
REQ-030 Shared package mem_pkg SHALL hold:
   - state enum;
   - DEPTH and WAIT_STATES defaults;
   - address width constant.
REQ-031 Sub-module mem_ram SHALL be a single-port synchronous RAM (1-cycle registered read, write-enable, no reset), instantiated once.
REQ-032 The FSM, wait counter, range check and handshake SHALL live in mem_responder.

Verification
REQ-033 Reset: nRst=0 mid-WAIT of a write of 0xDEADBEEF to address 5 -> oRdy=0, oData=0 immediately; a later read of address 5 returns the prior contents.
REQ-034 WAIT_STATES=2: write 0x12345678 to address 3, then read address 3 -> oRdy rises 4 cycles after each accepting edge; read returns oData=0x12345678, oErr=0.
REQ-035 WAIT_STATES=0: read address 0 -> oRdy high 2 cycles after acceptance; holding iRead high for 5 extra cycles -> oRdy stays high, oData stable, array accessed exactly once.
REQ-036 Read of address 512 (DEPTH=512) -> oErr=1, oData=0; write of 0xFFFFFFFF to address 0x1000 -> oErr=1, array unchanged.
REQ-037 iRead=iWrite=1 at address 7 -> oErr=1 and address 7 unchanged.
REQ-038 Back-to-back: request dropped the cycle after oRdy, new read raised the next cycle -> accepted on the edge after IDLE is re-entered, correct data returned.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-state memory responder.
package mem_pkg;

    localparam int unsigned DEPTH_DEF = 512;
    localparam int unsigned WAIT_DEF  = 2;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Processor-side request/response bundle of the memory responder.
interface mem_responder_if;
    import mem_pkg::*;

    logic [ADDR_W-1:0] iAddr;
    logic [DATA_W-1:0] iData;
    logic              iRead;
    logic              iWrite;
    logic [DATA_W-1:0] oData;
    logic              oRdy;
    logic              oErr;

    modport master (
        output iAddr, iData, iRead, iWrite,
        input  oData, oRdy, oErr
    );

    modport slave (
        input  iAddr, iData, iRead, iWrite,
        output oData, oRdy, oErr
    );

endinterface

// File: rtl/mem_ram.sv
// Single-port synchronous RAM: registered read, write-enable, no reset.
module mem_ram
    import mem_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read-first: a write cycle returns the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: request FSM, range check and handshake.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = WAIT_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF
) (
    input logic            iClk,
    input logic            nRst,
    mem_responder_if.slave bus
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_q;
    logic              wr_q;
    logic              err_q;
    logic [DATA_W-1:0] odata_q;
    logic              ordy_q;
    logic              oerr_q;

    logic              req_d;
    logic              err_d;
    logic              we_d;
    logic [IW-1:0]     ram_addr_d;
    logic [DATA_W-1:0] ram_rdata;

    assign req_d = bus.iRead | bus.iWrite;
    assign err_d = (bus.iRead & bus.iWrite)
                 | (bus.iAddr >= ADDR_W'(DEPTH));
    assign we_d  = (state_q == ACCESS) & wr_q & ~err_q;

    // In IDLE the RAM already reads the incoming address so the word
    // is ready by ACCESS even with no wait states.
    assign ram_addr_d = (state_q == IDLE) ? bus.iAddr[IW-1:0] : idx_q;

    mem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (iClk),
        .we_i    (we_d),
        .addr_i  (ram_addr_d),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            odata_q <= '0;
            ordy_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_d) begin
                        idx_q   <= bus.iAddr[IW-1:0];
                        wdata_q <= bus.iData;
                        rd_q    <= bus.iRead;
                        wr_q    <= bus.iWrite;
                        err_q   <= err_d;
                        if (WAIT_STATES == 0) begin
                            state_q <= ACCESS;
                        end else begin
                            cnt_q   <= CNT_W'(WAIT_STATES - 1);
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ACCESS: begin
                    state_q <= DONE;
                    ordy_q  <= 1'b1;
                    oerr_q  <= err_q;
                    if (rd_q) begin
                        odata_q <= err_q ? '0 : ram_rdata;
                    end
                end
                DONE: begin
                    if (!req_d) begin
                        state_q <= IDLE;
                        ordy_q  <= 1'b0;
                        oerr_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oData = odata_q;
    assign bus.oRdy  = ordy_q;
    assign bus.oErr  = oerr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder at two wait-state settings.
module tb_mem_responder;
    import mem_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rstA_n = 1'b1;
    logic rstB_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic prevA = 1'b0;
    logic prevB = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if a_if ();
    mem_responder_if b_if ();

    mem_responder #(.WAIT_STATES(2), .DEPTH(512)) dutA (
        .iClk (clk),
        .nRst (rstA_n),
        .bus  (a_if.slave)
    );

    mem_responder #(.WAIT_STATES(0), .DEPTH(512)) dutB (
        .iClk (clk),
        .nRst (rstB_n),
        .bus  (b_if.slave)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic mon_check(input string tag, input exp_t e,
                             input logic [31:0] d, input logic err,
                             input int ws);
        check({tag, " oData"}, d, e.data);
        check({tag, " oErr"}, {31'b0, err}, {31'b0, e.err});
        check({tag, " latency"}, 32'(cyc - e.acc + 1), 32'(ws + 2));
    endtask

    always @(negedge clk) begin
        if (a_if.oRdy === 1'b1 && !prevA) begin
            if (qa.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL A unexpected oRdy: got 1 want 0");
            end else begin
                mon_check("A", qa.pop_front(), a_if.oData, a_if.oErr, 2);
            end
        end
        prevA = (a_if.oRdy === 1'b1);
    end

    always @(negedge clk) begin
        if (b_if.oRdy === 1'b1 && !prevB) begin
            if (qb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL B unexpected oRdy: got 1 want 0");
            end else begin
                mon_check("B", qb.pop_front(), b_if.oData, b_if.oErr, 0);
            end
        end
        prevB = (b_if.oRdy === 1'b1);
    end

    function automatic logic rdy(input bit sel);
        return sel ? b_if.oRdy : a_if.oRdy;
    endfunction

    function automatic logic [31:0] dat(input bit sel);
        return sel ? b_if.oData : a_if.oData;
    endfunction

    task automatic drive(input bit sel, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            b_if.iRead  = rd;
            b_if.iWrite = wr;
            b_if.iAddr  = a;
            b_if.iData  = d;
        end else begin
            a_if.iRead  = rd;
            a_if.iWrite = wr;
            a_if.iAddr  = a;
            a_if.iData  = d;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge
    // after the request is dropped, ready for a back-to-back request.
    task automatic req(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input bit exp_e,
                       input int hold);
        exp_t        e;
        int          n;
        logic [31:0] held;
        drive(sel, rd, wr, a, d);
        e.data = exp_d;
        e.err  = exp_e;
        e.acc  = cyc + 1;
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rdy(sel) !== 1'b1 && n < 40);
        if (rdy(sel) !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL timeout oRdy: got 0 want 1 at addr %h", a);
        end
        held = dat(sel);
        repeat (hold) begin
            @(negedge clk);
            check("hold oRdy", {31'b0, rdy(sel)}, 32'd1);
            check("hold oData", dat(sel), held);
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("oRdy drop", {31'b0, rdy(sel)}, 32'd0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        rstA_n = 1'b0;
        rstB_n = 1'b0;
        #1;
        check("rst A oRdy", {31'b0, a_if.oRdy}, 32'd0);
        check("rst A oErr", {31'b0, a_if.oErr}, 32'd0);
        check("rst A oData", a_if.oData, 32'h0);
        check("rst B oRdy", {31'b0, b_if.oRdy}, 32'd0);
        check("rst B oData", b_if.oData, 32'h0);
        repeat (2) @(negedge clk);
        rstA_n = 1'b1;
        rstB_n = 1'b1;
        @(negedge clk);

        req(0, 0, 1, 32'd5, 32'hCAFEF00D, 32'h0, 0, 0);
        req(0, 1, 0, 32'd5, 32'h0, 32'hCAFEF00D, 0, 0);
        req(0, 0, 1, 32'd3, 32'h12345678, 32'hCAFEF00D, 0, 0);
        req(0, 1, 0, 32'd3, 32'h0, 32'h12345678, 0, 0);

        drive(0, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
        @(negedge clk);
        rstA_n = 1'b0;
        #1;
        check("abort oRdy", {31'b0, a_if.oRdy}, 32'd0);
        check("abort oData", a_if.oData, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rstA_n = 1'b1;
        @(negedge clk);
        req(0, 1, 0, 32'd5, 32'h0, 32'hCAFEF00D, 0, 0);

        req(0, 0, 1, 32'd0, 32'hA5A5A5A5, 32'hCAFEF00D, 0, 0);
        req(0, 1, 0, 32'd512, 32'h0, 32'h0, 1, 0);
        req(0, 0, 1, 32'h1000, 32'hFFFFFFFF, 32'h0, 1, 0);
        req(0, 1, 0, 32'd0, 32'h0, 32'hA5A5A5A5, 0, 0);
        req(0, 0, 1, 32'd7, 32'h77777777, 32'hA5A5A5A5, 0, 0);
        req(0, 1, 1, 32'd7, 32'h11111111, 32'h0, 1, 0);
        req(0, 1, 0, 32'd7, 32'h0, 32'h77777777, 0, 0);
        req(0, 1, 0, 32'd3, 32'h0, 32'h12345678, 0, 2);

        req(1, 0, 1, 32'd0, 32'h0BADC0DE, 32'h0, 0, 0);
        req(1, 1, 0, 32'd0, 32'h0, 32'h0BADC0DE, 0, 5);
        req(1, 0, 1, 32'd511, 32'h5A5A0001, 32'h0BADC0DE, 0, 0);
        req(1, 1, 0, 32'd511, 32'h0, 32'h5A5A0001, 0, 0);
        req(1, 1, 0, 32'd512, 32'h0, 32'h0, 1, 0);

        repeat (3) @(negedge clk);
        check("A queue empty", 32'(qa.size()), 32'd0);
        check("B queue empty", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
